// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 15;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// 4-bit loadable down-counter timing the memory read latency.
// to_zero flags the decrement that brings the count to zero.
module mem_arb_lat_cnt (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       to_zero
);

   logic [3:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 4'd0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != 4'd0)) begin
         count <= count - 4'd1;
      end
   end

   assign to_zero = dec && (count == 4'd1);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory between fetch and data ports; data wins ties.
// Define MEM_ARB_PERF_EN to enable the saturating conflict counter.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LAT = 2,
   parameter int AW      = 32,
   parameter int DW      = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ready,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ready,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          stall_if,
   output logic          stall_mem,
   output logic          busy,
   output logic [15:0]   conflict_cnt
);

   arb_state_t    state, state_next;
   owner_t        owner;
   logic          grant, grant_d;
   logic          cnt_load, cnt_dec, cnt_zero, capture;
   logic [DW-1:0] resp_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      grant      = 1'b0;
      grant_d    = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (d_req || if_req) begin
               grant      = 1'b1;
               grant_d    = d_req;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            cnt_load   = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            cnt_dec = 1'b1;
            if (cnt_zero) begin
               capture    = 1'b1;
               state_next = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   mem_arb_lat_cnt u_lat_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (4'(MEM_LAT)),
      .dec      (cnt_dec),
      .to_zero  (cnt_zero)
   );

   // mem_en is set at the grant edge so it is high during ISSUE only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner     <= OWN_IF;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         resp_data <= '0;
      end else begin
         mem_en <= grant;
         if (grant) begin
            owner     <= grant_d ? OWN_D : OWN_IF;
            mem_we    <= grant_d & d_we;
            mem_addr  <= grant_d ? d_addr : if_addr;
            mem_wdata <= grant_d ? d_wdata : '0;
         end
         if (capture) begin
            resp_data <= mem_we ? '0 : mem_rdata;
         end
      end
   end

   // A requester that dropped its req before RESP sees no ready pulse.
   assign if_ready  = (state == RESP) && (owner == OWN_IF) && if_req;
   assign d_ready   = (state == RESP) && (owner == OWN_D) && d_req;
   assign if_rdata  = resp_data;
   assign d_rdata   = resp_data;
   assign stall_if  = if_req & ~if_ready;
   assign stall_mem = d_req & ~d_ready;
   assign busy      = (state != IDLE);

`ifdef MEM_ARB_PERF_EN
   logic [15:0] conflict_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_q <= 16'd0;
      end else if ((state == IDLE) && if_req && d_req && (conflict_q != 16'hFFFF)) begin
         conflict_q <= conflict_q + 16'd1;
      end
   end

   assign conflict_cnt = conflict_q;
`else
   assign conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_LAT 2 (main), 1 and 15.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
`ifdef MEM_ARB_PERF_EN
   localparam logic [15:0] EXP_CONF = 16'd1;
`else
   localparam logic [15:0] EXP_CONF = 16'd0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req, d_req, d_we, req_l1, req_l15;
   logic [AW-1:0] if_addr, d_addr;
   logic [DW-1:0] d_wdata, mem_rdata;

   logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic          if_ready, d_ready, mem_en, mem_we, stall_if, stall_mem, busy;
   logic [15:0]   conflict_cnt;

   logic [DW-1:0] l1_if_rdata, l1_d_rdata, l1_mem_wdata;
   logic [AW-1:0] l1_mem_addr;
   logic          l1_if_ready, l1_d_ready, l1_mem_en, l1_mem_we, l1_stall_if, l1_stall_mem, l1_busy;
   logic [15:0]   l1_conflict_cnt;

   logic [DW-1:0] l15_if_rdata, l15_d_rdata, l15_mem_wdata;
   logic [AW-1:0] l15_mem_addr;
   logic          l15_if_ready, l15_d_ready, l15_mem_en, l15_mem_we, l15_stall_if, l15_stall_mem, l15_busy;
   logic [15:0]   l15_conflict_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_LAT(2), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem),
      .busy(busy), .conflict_cnt(conflict_cnt)
   );

   mem_port_arbiter #(.MEM_LAT(1), .AW(AW), .DW(DW)) dut_l1 (
      .clk(clk), .rst_n(rst_n),
      .if_req(req_l1), .if_addr(if_addr), .if_rdata(l1_if_rdata), .if_ready(l1_if_ready),
      .d_req(1'b0), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(l1_d_rdata), .d_ready(l1_d_ready),
      .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
      .mem_rdata(mem_rdata), .stall_if(l1_stall_if), .stall_mem(l1_stall_mem),
      .busy(l1_busy), .conflict_cnt(l1_conflict_cnt)
   );

   mem_port_arbiter #(.MEM_LAT(15), .AW(AW), .DW(DW)) dut_l15 (
      .clk(clk), .rst_n(rst_n),
      .if_req(req_l15), .if_addr(if_addr), .if_rdata(l15_if_rdata), .if_ready(l15_if_ready),
      .d_req(1'b0), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(l15_d_rdata), .d_ready(l15_d_ready),
      .mem_en(l15_mem_en), .mem_we(l15_mem_we), .mem_addr(l15_mem_addr), .mem_wdata(l15_mem_wdata),
      .mem_rdata(mem_rdata), .stall_if(l15_stall_if), .stall_mem(l15_stall_mem),
      .busy(l15_busy), .conflict_cnt(l15_conflict_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req    = 1'b0;
      if_addr   = '0;
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_addr    = '0;
      d_wdata   = '0;
      mem_rdata = '0;
      req_l1    = 1'b0;
      req_l15   = 1'b0;
   endtask

   // Leaves the bench at the start of cycle 0 with all instances in IDLE.
   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      next_cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      chk("rst_main_ctrl", {mem_en, mem_we, if_ready, d_ready, busy, stall_if, stall_mem}, 0);
      chk("rst_main_data", {mem_addr, mem_wdata}, 0);
      chk("rst_main_rdata", {if_rdata, d_rdata}, 0);
      chk("rst_main_conf", conflict_cnt, 0);
      chk("rst_l1_all", |{l1_if_rdata, l1_d_rdata, l1_mem_wdata, l1_mem_addr, l1_if_ready,
                          l1_d_ready, l1_mem_en, l1_mem_we, l1_stall_if, l1_stall_mem,
                          l1_busy, l1_conflict_cnt}, 0);
      chk("rst_l15_all", |{l15_if_rdata, l15_d_rdata, l15_mem_wdata, l15_mem_addr, l15_if_ready,
                           l15_d_ready, l15_mem_en, l15_mem_we, l15_stall_if, l15_stall_mem,
                           l15_busy, l15_conflict_cnt}, 0);

      // Lone fetch
      do_reset();
      for (int c = 0; c <= 5; c++) begin
         if_req    = (c <= 4);
         if_addr   = 32'h100;
         mem_rdata = (c == 3) ? 32'hDEADBEEF : 32'h0;
         @(negedge clk);
         chk($sformatf("fetch_mem_en_c%0d", c), mem_en, (c == 1));
         chk($sformatf("fetch_stall_if_c%0d", c), stall_if, (c <= 3));
         chk($sformatf("fetch_if_ready_c%0d", c), if_ready, (c == 4));
         if (c == 1) chk("fetch_mem_addr", {mem_we, mem_addr}, {1'b0, 32'h100});
         if (c == 4) chk("fetch_if_rdata", if_rdata, 32'hDEADBEEF);
         if (c == 5) chk("fetch_busy_after", busy, 0);
         next_cycle();
      end

      // Simultaneous data load and fetch: data first
      do_reset();
      for (int c = 0; c <= 10; c++) begin
         d_req     = (c <= 4);
         d_we      = 1'b0;
         d_addr    = 32'h200;
         if_req    = (c <= 9);
         if_addr   = 32'h300;
         mem_rdata = (c == 3) ? 32'h1111 : ((c == 8) ? 32'h2222 : 32'h0);
         @(negedge clk);
         chk($sformatf("conf_mem_en_c%0d", c), mem_en, (c == 1 || c == 6));
         chk($sformatf("conf_d_ready_c%0d", c), d_ready, (c == 4));
         chk($sformatf("conf_if_ready_c%0d", c), if_ready, (c == 9));
         chk($sformatf("conf_stall_mem_c%0d", c), stall_mem, (c <= 3));
         chk($sformatf("conf_stall_if_c%0d", c), stall_if, (c <= 8));
         if (c == 1) chk("conf_addr_d", mem_addr, 32'h200);
         if (c == 6) chk("conf_addr_if", mem_addr, 32'h300);
         if (c == 4) chk("conf_d_rdata", d_rdata, 32'h1111);
         if (c == 9) chk("conf_if_rdata", if_rdata, 32'h2222);
         if (c == 9) chk("conf_cnt", conflict_cnt, EXP_CONF);
         next_cycle();
      end

      // Store
      do_reset();
      for (int c = 0; c <= 5; c++) begin
         d_req     = (c <= 4);
         d_we      = 1'b1;
         d_addr    = 32'h40;
         d_wdata   = 32'h55;
         mem_rdata = 32'hFFFFFFFF;
         @(negedge clk);
         chk($sformatf("store_mem_en_c%0d", c), mem_en, (c == 1));
         chk($sformatf("store_d_ready_c%0d", c), d_ready, (c == 4));
         if (c == 1) chk("store_issue", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h40, 32'h55});
         if (c == 4) chk("store_d_rdata", d_rdata, 32'h0);
         next_cycle();
      end

      // Aborted fetch
      do_reset();
      for (int c = 0; c <= 5; c++) begin
         if_req    = (c <= 1);
         if_addr   = 32'h80;
         mem_rdata = 32'h77;
         @(negedge clk);
         chk($sformatf("abort_mem_en_c%0d", c), mem_en, (c == 1));
         chk($sformatf("abort_if_ready_c%0d", c), if_ready, 0);
         chk($sformatf("abort_busy_c%0d", c), busy, (c >= 1 && c <= 4));
         next_cycle();
      end

      // Reset asserted mid-WAIT
      do_reset();
      for (int c = 0; c <= 1; c++) begin
         if_req    = 1'b1;
         if_addr   = 32'h123;
         mem_rdata = 32'hABCD;
         next_cycle();
      end
      rst_n  = 1'b0;
      if_req = 1'b0;
      #1;
      chk("midrst_ctrl", {mem_en, mem_we, if_ready, d_ready, busy, stall_if, stall_mem}, 0);
      chk("midrst_data", {mem_addr, mem_wdata, if_rdata}, 0);
      next_cycle();
      rst_n = 1'b1;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         chk($sformatf("midrst_after_c%0d", c), {if_ready, busy, mem_en}, 0);
         next_cycle();
      end

      // Latency extremes
      do_reset();
      for (int c = 0; c <= 18; c++) begin
         req_l1  = (c <= 3);
         req_l15 = (c <= 17);
         if_addr = 32'h10;
         @(negedge clk);
         chk($sformatf("lat1_ready_c%0d", c), l1_if_ready, (c == 3));
         chk($sformatf("lat15_ready_c%0d", c), l15_if_ready, (c == 17));
         next_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
